// File: rtl/d_latch.sv
// d_latch: level-sensitive D latch bank; clk is the latch enable.
// Ports: d (WIDTH) data in; q (WIDTH) latched data out;
//   q_n (WIDTH) inverted q, present only with D_LATCH_QN_EN;
//   clk enable, transparent high; rst_n active-low reset,
//   applied only while clk=1, pulled high if left open;
//   open_o high while the latch is transparent.
// Params: WIDTH data bits, RESET_VAL value loaded by reset.
// Optional feature macro: D_LATCH_QN_EN adds q_n after q.
module d_latch #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
`ifdef D_LATCH_QN_EN
  output logic [WIDTH-1:0] q_n,
`endif
  input  logic             clk,
  input  tri1              rst_n,
  output logic             open_o
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load;
  logic             w_en;

  assign w_en = clk;

  // Reset only takes effect through the open latch, so it is
  // folded into the data path rather than forcing q directly.
  assign w_load = rst_n ? d : RESET_VAL;

  // Incomplete if: q holds while the enable is low.
  always_latch begin
    if (w_en) begin
      r_q <= w_load;
    end
  end

  assign q      = r_q;
  assign open_o = clk & rst_n;

`ifdef D_LATCH_QN_EN
  assign q_n = ~r_q;
`endif

endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: directed bench for d_latch, 1-bit default
// instance and 8-bit instance with RESET_VAL 8'hA5.
module tb_d_latch;

  logic       clk;
  logic       rst_n;
  logic       d1;
  logic       q1;
  logic       o1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic       o8;
`ifdef D_LATCH_QN_EN
  logic       qn1;
  logic [7:0] qn8;
`endif

  int checks;
  int errors;

  d_latch u_w1 (
    .d      (d1),
    .q      (q1),
`ifdef D_LATCH_QN_EN
    .q_n    (qn1),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .open_o (o1)
  );

  d_latch #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) u_w8 (
    .d      (d8),
    .q      (q8),
`ifdef D_LATCH_QN_EN
    .q_n    (qn8),
`endif
    .clk    (clk),
    .rst_n  (rst_n),
    .open_o (o8)
  );

  task automatic test_reset();
    clk   = 1'b0;
    rst_n = 1'b0;
    d1    = 1'b1;
    d8    = 8'h3C;
    #2 clk = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_q1 got %b exp %b", q1, 1'b0);
    end
    checks++;
    if (q8 !== 8'hA5) begin
      errors++;
      $display("FAIL reset_q8 got %h exp %h", q8, 8'hA5);
    end
    checks++;
    if (o1 !== 1'b0 || o8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_open got %b%b exp 00", o1, o8);
    end
`ifdef D_LATCH_QN_EN
    checks++;
    if (qn8 !== 8'h5A || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_qn got %b %h exp 1 5a", qn1, qn8);
    end
`endif
    // low phase under reset: q keeps reset value
    clk = 1'b0;
    #1;
    checks++;
    if (q8 !== 8'hA5) begin
      errors++;
      $display("FAIL reset_lowhold got %h exp %h", q8, 8'hA5);
    end
  endtask

  task automatic test_transparency();
    clk = 1'b1;
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      errors++;
      $display("FAIL rel_q got %b %h exp 1 3c", q1, q8);
    end
    checks++;
    if (o1 !== 1'b1 || o8 !== 1'b1) begin
      errors++;
      $display("FAIL trans_open got %b%b exp 11", o1, o8);
    end
    d1 = 1'b0;
    d8 = 8'h81;
    #1;
    checks++;
    if (q1 !== 1'b0 || q8 !== 8'h81) begin
      errors++;
      $display("FAIL trans_fall got %b %h exp 0 81", q1, q8);
    end
    d1 = 1'b1;
    d8 = 8'h3C;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      errors++;
      $display("FAIL trans_rise got %b %h exp 1 3c", q1, q8);
    end
`ifdef D_LATCH_QN_EN
    checks++;
    if (qn8 !== 8'hC3 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL trans_qn got %b %h exp 0 c3", qn1, qn8);
    end
`endif
  endtask

  task automatic test_hold();
    clk = 1'b0;
    #1;
    checks++;
    if (o1 !== 1'b0 || o8 !== 1'b0) begin
      errors++;
      $display("FAIL hold_open got %b%b exp 00", o1, o8);
    end
    d1 = 1'b0;
    d8 = 8'hFF;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      errors++;
      $display("FAIL hold_q got %b %h exp 1 3c", q1, q8);
    end
    d1 = 1'b1;
    d8 = 8'h00;
    #1 d1 = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      errors++;
      $display("FAIL hold_toggle got %b %h exp 1 3c", q1, q8);
    end
`ifdef D_LATCH_QN_EN
    checks++;
    if (qn8 !== 8'hC3 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_qn got %b %h exp 0 c3", qn1, qn8);
    end
`endif
  endtask

  task automatic test_reset_in_hold();
    rst_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h3C) begin
      errors++;
      $display("FAIL rsthold_q got %b %h exp 1 3c", q1, q8);
    end
    d1 = 1'b1;
    d8 = 8'h77;
    #1 clk = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0 || q8 !== 8'hA5) begin
      errors++;
      $display("FAIL rsthold_rise got %b %h exp 0 a5", q1, q8);
    end
  endtask

  task automatic test_reset_mid_high();
    rst_n = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b1 || q8 !== 8'h77) begin
      errors++;
      $display("FAIL midhi_rel got %b %h exp 1 77", q1, q8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || q8 !== 8'hA5) begin
      errors++;
      $display("FAIL midhi_assert got %b %h exp 0 a5", q1, q8);
    end
`ifdef D_LATCH_QN_EN
    checks++;
    if (qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL midhi_qn got %h exp 5a", qn8);
    end
`endif
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_bits();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) begin
      v   = 8'h01 << i;
      clk = 1'b1;
      d8  = v;
      #1 clk = 1'b0;
      #1 d8 = ~v;
      #1;
      checks++;
      if (q8 !== v) begin
        errors++;
        $display("FAIL bit%0d got %h exp %h", i, q8, v);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    rst_n  = 1'b1;
    d1     = 1'b0;
    d8     = 8'h00;
    test_reset();
    test_transparency();
    test_hold();
    test_reset_in_hold();
    test_reset_mid_high();
    test_bits();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
